// File: rtl/au_modsub_multi.sv
// Pipelined modular add/subtract unit with selectable moduli, tag passthrough,
// range checking, a level done flag and an optional auto-issue after reset release.
module au_modsub_multi #(
    parameter int                 W          = 110,
    parameter int                 NMOD       = 2,
    parameter logic [NMOD*W-1:0]  MODULI     = {NMOD{{W{1'b1}}}},
    parameter int                 LAT        = 2,
    parameter int                 TAGW       = 4,
    parameter int                 AUTO_START = 1,
    localparam int                MSW        = (NMOD > 1) ? $clog2(NMOD) : 1
) (
    input  logic            clk,
    input  logic            AU_sub_rst,
    input  logic            in_valid,
    input  logic            op_add,
    input  logic [MSW-1:0]  mod_sel,
    input  logic [TAGW-1:0] in_tag,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    r,
    output logic [TAGW-1:0] r_tag,
    output logic            out_valid,
    output logic            range_err,
    output logic            busy,
    output logic            done
);

    localparam int unsigned NMOD_U = NMOD;

    logic            started;
    logic            seen;
    logic            auto_pulse;
    logic            iv;

    logic [W-1:0]    m_sel;
    logic [W:0]      sum_in;
    logic            err_in;

    logic [W:0]      s1_sum;
    logic [W-1:0]    s1_m;
    logic            s1_op;
    logic            s1_err;
    logic [TAGW-1:0] s1_tag;

    logic [W:0]      corr;
    logic [W-1:0]    res2;

    logic [LAT:1]    v;
    logic [W-1:0]    r_q   [2:LAT];
    logic [TAGW-1:0] tag_q [2:LAT];
    logic            err_q [2:LAT];

    assign auto_pulse = ~started & (AUTO_START != 0);
    assign iv         = in_valid | auto_pulse;

    always_comb begin
        m_sel = '0;
        for (int i = 0; i < NMOD; i++) begin
            if (32'(mod_sel) == 32'(i)) begin
                m_sel = MODULI[i*W +: W];
            end
        end
    end

    // W+1-bit intermediate: bit W is the borrow for subtract, the carry for add.
    always_comb begin
        sum_in = op_add ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
        err_in = (a >= m_sel) | (b >= m_sel) | (32'(mod_sel) >= NMOD_U);
    end

    always_comb begin
        corr = s1_sum;
        if (s1_op) begin
            if (s1_sum >= {1'b0, s1_m}) begin
                corr = s1_sum - {1'b0, s1_m};
            end
        end else if (s1_sum[W]) begin
            corr = s1_sum + {1'b0, s1_m};
        end
        res2 = s1_err ? '0 : corr[W-1:0];
    end

    always_ff @(posedge clk or posedge AU_sub_rst) begin
        if (AU_sub_rst) begin
            started <= 1'b0;
            seen    <= 1'b0;
            v       <= '0;
            s1_sum  <= '0;
            s1_m    <= '0;
            s1_op   <= 1'b0;
            s1_err  <= 1'b0;
            s1_tag  <= '0;
            for (int k = 2; k <= LAT; k++) begin
                r_q[k]   <= '0;
                tag_q[k] <= '0;
                err_q[k] <= 1'b0;
            end
        end else begin
            started <= 1'b1;
            // Set on the edge that loads a result into the output stage.
            seen    <= seen | v[LAT-1];

            v[1] <= iv;
            if (iv) begin
                s1_sum <= sum_in;
                s1_m   <= m_sel;
                s1_op  <= op_add;
                s1_err <= err_in;
                s1_tag <= in_tag;
            end

            v[2]     <= v[1];
            err_q[2] <= v[1] & s1_err;
            if (v[1]) begin
                r_q[2]   <= res2;
                tag_q[2] <= s1_tag;
            end

            for (int k = 3; k <= LAT; k++) begin
                v[k]     <= v[k-1];
                err_q[k] <= v[k-1] & err_q[k-1];
                if (v[k-1]) begin
                    r_q[k]   <= r_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
            end
        end
    end

    // The output stage only presents a finished result, so it does not count as busy.
    assign busy      = |v[LAT-1:1];
    assign done      = seen & ~busy;
    assign out_valid = v[LAT];
    assign r         = r_q[LAT];
    assign r_tag     = tag_q[LAT];
    assign range_err = err_q[LAT];

endmodule

// File: tb/tb_au_modsub_multi.sv
// Self-checking bench for au_modsub_multi: directed vector table, back-to-back,
// range error, auto-start, reset abort and randomized traffic against a reference model.
module tb_au_modsub_multi;

    localparam int W = 8;
    localparam logic [15:0] MODS = {8'd239, 8'd251};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst1 = 1'b1, rst4 = 1'b1;
    logic       iv0 = 1'b0, iv1 = 1'b0, iv4 = 1'b0;
    logic       op_add = 1'b0;
    logic [0:0] mod_sel = 1'b0;
    logic [3:0] tag = 4'd0;
    logic [7:0] a = 8'd0, b = 8'd0;

    logic [7:0] r0, r1, r4;
    logic [3:0] t0, t1, t4;
    logic       ov0, ov1, ov4, re0, re1, re4, bz0, bz1, bz4, dn0, dn1, dn4;

    au_modsub_multi #(.W(W), .NMOD(2), .MODULI(MODS), .LAT(2), .TAGW(4), .AUTO_START(0)) dut0 (
        .clk(clk), .AU_sub_rst(rst0), .in_valid(iv0), .op_add(op_add), .mod_sel(mod_sel),
        .in_tag(tag), .a(a), .b(b), .r(r0), .r_tag(t0), .out_valid(ov0), .range_err(re0),
        .busy(bz0), .done(dn0));

    au_modsub_multi #(.W(W), .NMOD(2), .MODULI(MODS), .LAT(2), .TAGW(4), .AUTO_START(1)) dut1 (
        .clk(clk), .AU_sub_rst(rst1), .in_valid(iv1), .op_add(op_add), .mod_sel(mod_sel),
        .in_tag(tag), .a(a), .b(b), .r(r1), .r_tag(t1), .out_valid(ov1), .range_err(re1),
        .busy(bz1), .done(dn1));

    au_modsub_multi #(.W(W), .NMOD(2), .MODULI(MODS), .LAT(4), .TAGW(4), .AUTO_START(0)) dut4 (
        .clk(clk), .AU_sub_rst(rst4), .in_valid(iv4), .op_add(op_add), .mod_sel(mod_sel),
        .in_tag(tag), .a(a), .b(b), .r(r4), .r_tag(t4), .out_valid(ov4), .range_err(re4),
        .busy(bz4), .done(dn4));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on integers; returns {err, r}.
    function automatic logic [8:0] model(input logic op, input logic ms, input int x, input int y);
        int m;
        int res;
        m = ms ? 239 : 251;
        if (x >= m || y >= m) return {1'b1, 8'd0};
        res = op ? (x + y) % m : (x - y + m) % m;
        return {1'b0, 8'(res)};
    endfunction

    typedef struct packed {
        logic       op;
        logic       ms;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] tag;
        logic [7:0] r;
        logic       err;
    } vec_t;

    vec_t vecs [11];

    task automatic run_one(input vec_t v);
        int   n;
        logic got;
        @(negedge clk);
        op_add = v.op; mod_sel = v.ms; a = v.a; b = v.b; tag = v.tag; iv0 = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            iv0 = 1'b0;
            n++;
            if (ov0) got = 1'b1;
        end
        chk("vec_result_seen", got, 1);
        if (got) begin
            chk("vec_latency", n, 2);
            chk("vec_r", r0, v.r);
            chk("vec_tag", t0, v.tag);
            chk("vec_range_err", re0, v.err);
            chk("vec_done_with_result", dn0, 1);
            @(negedge clk);
            chk("vec_pulse_one_cycle", ov0, 0);
            chk("vec_err_idle", re0, 0);
            chk("vec_r_hold", r0, v.r);
            chk("vec_done_after", dn0, 1);
        end
    endtask

    logic [12:0] exp_q [$];
    logic [12:0] e;
    logic [8:0]  mres;
    logic [7:0]  bb_r [4];
    int          pulses;
    int          n;
    logic        got;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 8'd5,   8'd9,   4'd3,  8'd247, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'd250, 8'd250, 4'd1,  8'd249, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'd200, 8'd39,  4'd2,  8'd0,   1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'd7,   8'd7,   4'd4,  8'd0,   1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'd240, 8'd1,   4'd5,  8'd0,   1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'd240, 8'd1,   4'd6,  8'd239, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'd0,   8'd250, 4'd7,  8'd1,   1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'd100, 8'd151, 4'd8,  8'd0,   1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'd238, 8'd238, 4'd9,  8'd237, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'd255, 8'd255, 4'd10, 8'd0,   1'b1};
        vecs[10] = '{1'b1, 1'b1, 8'd200, 8'd100, 4'd11, 8'd61,  1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", ov0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_r", r0, 0);
        chk("rst_range_err", re0, 0);
        chk("rst_auto_done", dn1, 0);
        rst0 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);
        chk("no_auto_issue_busy", bz0, 0);
        chk("no_result_yet_done", dn0, 0);

        for (int i = 0; i < 11; i++) run_one(vecs[i]);

        // Four back-to-back operations, tags 0..3
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                chk("b2b_busy", bz0, 1);
                chk("b2b_done_low", dn0, 0);
            end
            if (i >= 2 && i <= 5) begin
                chk("b2b_out_valid", ov0, 1);
                chk("b2b_tag", t0, 32'(i - 2));
                chk("b2b_r", r0, bb_r[i-2]);
            end
            if (i == 6) begin
                chk("b2b_done_after", dn0, 1);
                chk("b2b_idle", ov0, 0);
            end
            if (i < 4) begin
                op_add = i[0] ? 1'b0 : 1'b1;
                mod_sel = i[1];
                a = 8'(40 * i + 100);
                b = 8'(60 * i + 7);
                tag = 4'(i);
                mres = model(op_add, mod_sel, int'(a), int'(b));
                bb_r[i] = mres[7:0];
                iv0 = 1'b1;
            end else begin
                iv0 = 1'b0;
            end
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 320; c++) begin
            @(negedge clk);
            if (ov0) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_r", r0, e[7:0]);
                    chk("rand_err", re0, e[8]);
                    chk("rand_tag", t0, e[12:9]);
                end
            end else begin
                chk("rand_err_idle", re0, 0);
            end
            if (c < 300 && $urandom_range(0, 3) != 0) begin
                op_add = 1'($urandom_range(0, 1));
                mod_sel = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0) begin
                    a = 8'($urandom_range(0, 255));
                    b = 8'($urandom_range(0, 255));
                end else begin
                    a = 8'($urandom_range(0, mod_sel ? 238 : 250));
                    b = 8'($urandom_range(0, mod_sel ? 238 : 250));
                end
                tag = 4'($urandom_range(0, 15));
                mres = model(op_add, mod_sel, int'(a), int'(b));
                exp_q.push_back({tag, mres});
                iv0 = 1'b1;
            end else begin
                iv0 = 1'b0;
            end
        end
        chk("rand_queue_drained", exp_q.size(), 0);

        // Auto-start: one implicit subtract 10-3 on the first edge after release
        @(negedge clk);
        a = 8'd10; b = 8'd3; op_add = 1'b0; mod_sel = 1'b0; tag = 4'd6;
        rst1 = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ov1) pulses++;
            if (k == 1) begin
                chk("auto_busy", bz1, 1);
                chk("auto_done_early", dn1, 0);
            end
            if (k == 2) begin
                chk("auto_out_valid", ov1, 1);
                chk("auto_r", r1, 7);
                chk("auto_done_two_edges", dn1, 1);
            end
            if (k >= 3) chk("auto_done_held", dn1, 1);
        end
        chk("auto_single_result", pulses, 1);
        #2 rst1 = 1'b1;
        #1;
        chk("auto_async_r", r1, 0);
        chk("auto_async_done", dn1, 0);
        chk("auto_async_busy", bz1, 0);

        // in_valid high on the auto edge still issues only one operation
        @(negedge clk);
        rst1 = 1'b0;
        iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ov1) pulses++;
        end
        chk("auto_or_single", pulses, 1);

        // LAT=4: reset while in flight aborts; then a fresh issue lands after LAT edges
        @(negedge clk);
        a = 8'd20; b = 8'd30; op_add = 1'b1; mod_sel = 1'b0; tag = 4'd12;
        iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        chk("lat4_busy_in_flight", bz4, 1);
        rst4 = 1'b1;
        #1;
        chk("lat4_busy_cleared", bz4, 0);
        @(negedge clk);
        rst4 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov4) pulses++;
        end
        chk("lat4_aborted_no_result", pulses, 0);
        chk("lat4_done_after_abort", dn4, 0);

        a = 8'd5; b = 8'd6; op_add = 1'b1; mod_sel = 1'b0; tag = 4'd9;
        iv4 = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 12) begin
            @(negedge clk);
            iv4 = 1'b0;
            n++;
            if (ov4) got = 1'b1;
        end
        chk("lat4_result_seen", got, 1);
        if (got) begin
            chk("lat4_latency", n, 4);
            chk("lat4_r", r4, 11);
            chk("lat4_tag", t4, 9);
            chk("lat4_done", dn4, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
